// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: bundles the core request/response handshakes and the data RAM port
// used by dmem_lsu.
//   req_*  : core -> LSU request (valid/ready, we, addr, wdata)
//   resp_* : LSU -> core response (valid/ready, rdata, err)
//   mem_*  : LSU -> RAM address/write data/write enable, RAM -> LSU read data
// Modports: slave = the LSU side, master = the core + RAM side.
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for the 64x8 data RAM. Accepts one request at a time
// from the core, drives the RAM port, waits MEM_RD_LAT+1 cycles for load data and
// returns a response (load data or store ack) over a valid/ready handshake.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - dmem_lsu_if.slave (request, response and RAM port signals)
// Optional feature: define DMEM_LSU_WRITE_VERIFY_EN to read back every store and
// flag a mismatch against the written data in resp_err.
module dmem_lsu #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input logic       clk,
  input logic       reset,
  dmem_lsu_if.slave bus
);

  localparam logic [ADDR_W:0] DepthLim = DEPTH[ADDR_W:0];
  localparam logic [1:0]      LatLast  = MEM_RD_LAT[1:0];

  typedef enum logic [2:0] {
`ifdef DMEM_LSU_WRITE_VERIFY_EN
    StVerify,
`endif
    StIdle,
    StWrite,
    StRead,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                addr_oor;

  // Zero-extend so DEPTH == 2**ADDR_W still compares correctly.
  assign addr_oor = ({1'b0, bus.req_addr} >= DepthLim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (addr_oor) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else if (bus.req_we) begin
            state_d     = StWrite;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
            mem_we_d    = 1'b1;
          end else begin
            state_d    = StRead;
            mem_addr_d = bus.req_addr;
            cnt_d      = '0;
          end
        end
      end
      StWrite: begin
`ifdef DMEM_LSU_WRITE_VERIFY_EN
        state_d = StVerify;
        cnt_d   = '0;
`else
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
`endif
      end
      StRead: begin
        // Address held for MEM_RD_LAT+1 cycles; data sampled on the closing edge.
        if (cnt_q == LatLast) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rdata_d = bus.mem_rdata;
          resp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`ifdef DMEM_LSU_WRITE_VERIFY_EN
      StVerify: begin
        // Read-back of the just-written line; mem_wdata_q still holds the store data.
        if (cnt_q == LatLast) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rdata_d = bus.mem_rdata;
          resp_err_d   = (bus.mem_rdata != mem_wdata_q);
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`endif
      StResp: begin
        if (bus.resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;

endmodule
